// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets two masters share one synchronous single-port data RAM.
// Port 0 is the CPU load/store path and port 1 is the DMA/debug master.
// Only one transaction is in flight at a time: accept, then memory strobe,
// then response. Nothing can be accepted while a transaction is outstanding.
// Arbitration: by default port 0 has priority, and a MAX_BURST starvation
// guard stops it from locking out port 1. Define DMEM_ARB_RR_EN to use
// round-robin arbitration instead.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic [3:0]        req0_be,
  input  logic [31:0]       req0_wdata,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [3:0]        req1_be,
  input  logic [31:0]       req1_wdata,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("dmem_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;        // 1 = port 1 owns the access
  logic                rsp_load_q, rsp_load_d;  // the response belongs to a load
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                grant;
  logic                pick1;                   // the grant goes to port 1

  assign grant = (state_q == IDLE) && (req0_valid || req1_valid);

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;  // port granted most recently

  // Round-robin: when both ports request, the one not granted last wins.
  always_comb begin
    pick1  = req1_valid && (!req0_valid || !last_q);
    last_d = grant ? pick1 : last_q;
  end

  // Last-grant pointer. It resets to port 1 so port 0 wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // Fixed priority for port 0. Port 1 takes a turn once port 0 has won
  // MAX_BURST grants in a row while port 1 was waiting.
  always_comb begin
    pick1       = req1_valid && (!req0_valid || (burst_cnt_q == CNT_W'(MAX_BURST)));
    burst_cnt_d = burst_cnt_q;
    if (grant) begin
      if (pick1 || !req1_valid) burst_cnt_d = '0;
      else                      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end
`endif

  // Ready is combinational to the winner. It is held low during reset,
  // because the state register reads IDLE while reset is asserted.
  assign req0_ready = grant && !pick1 && !rst;
  assign req1_ready = grant &&  pick1 && !rst;

  // Next-state and datapath decode for IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    rsp_load_d   = rsp_load_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = ACCESS;
          owner_d     = pick1;
          mem_en_d    = 1'b1;
          mem_we_d    = pick1 ? req1_we : req0_we;
          mem_addr_d  = pick1 ? req1_addr : req0_addr;
          mem_wdata_d = pick1 ? req1_wdata : req0_wdata;
          // Reads never carry byte enables. A store with be=0000 passes through unchanged.
          mem_be_d    = mem_we_d ? (pick1 ? req1_be : req0_be) : 4'b0000;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        rsp_load_d   = !mem_we_q;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d =  owner_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears everything, including any
  // in-flight access, so no response is produced after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rsp_load_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all flops update together from pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      rsp_load_q   <= rsp_load_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  // The RAM presents its read data in the RESP cycle. That data is gated
  // through only by registered flags, so the response still arrives two
  // cycles after acceptance, and the output is zero at all other times.
  assign rsp0_rdata = (rsp0_valid_q && rsp_load_q) ? mem_rdata : 32'h0;
  assign rsp1_rdata = (rsp1_valid_q && rsp_load_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
// It applies a table of single transactions, then runs hand-written
// sequences for reset, arbitration order and back-to-back spacing.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_be;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_be;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_we(req0_we), .req0_be(req0_be), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_be(req1_be), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata_in;   // value the RAM returns in the RESP cycle
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  logic exp_order[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    if (port) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_be = be; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_be = be; req0_wdata = wdata;
    end
  endtask

  // Watches grants while the request inputs are held. It checks each winner
  // and checks that consecutive grants are exactly three cycles apart.
  task automatic run_grants(input int n, input bit lone1, input string tag);
    for (int g = 0; g < n; g++) begin
      int  c;
      bit  found;
      logic exp1;
      exp1  = lone1 ? 1'b1 : exp_order[g];
      c     = 0;
      found = 1'b0;
      while (!found && c < 8) begin
        @(negedge clk);
        c++;
        if (req0_ready || req1_ready) begin
          found = 1'b1;
          check($sformatf("%s_grant%0d", tag, g), {62'd0, req1_ready, req0_ready},
                exp1 ? 64'd2 : 64'd1);
        end
      end
      if (!found)     check($sformatf("%s_timeout%0d", tag, g), 64'd0, 64'd1);
      else if (g > 0) check($sformatf("%s_gap%0d", tag, g), 64'(c), 64'd3);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int viol;

    //        port  we    addr          be       wdata         rdata_in      exp_be   exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,        32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0024, 4'b1100, 32'h1234_5678, 32'hAAAA_AAAA, 4'b1100, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 4'b0000, 32'hCAFE_F00D, 32'h7777_7777, 4'b0000, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 4'b0011, 32'h0,        32'h0BAD_C0DE, 4'b0000, 32'h0BAD_C0DE};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0003, 4'b0001, 32'h0000_00FF, 32'h5555_5555, 4'b0001, 32'h0};

`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 10; i++) exp_order[i] = 1'(i % 2);
`else
    for (int i = 0; i < 10; i++) exp_order[i] = (i == 4 || i == 9);
`endif

    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_be = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_be = '0; req1_wdata = '0;
    mem_rdata  = '0;

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {58'd0, mem_en, mem_we, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_data", {mem_wdata, 28'd0, mem_be}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during the ACCESS cycle of a port-0 load.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h10, 4'hF, 32'h1111_1111);
    @(posedge clk); #1;
    check("midrst_access", 64'(mem_en), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {58'd0, mem_en, mem_we, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    check("midrst_data", {mem_wdata, 28'd0, mem_be}, 64'd0);
    check("midrst_rdata", {rsp0_rdata, rsp1_rdata}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || mem_en) viol++;
    end
    check("midrst_no_rsp", 64'(viol), 64'd0);

    // Single transactions from the vector table.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), {62'd0, req1_ready, req0_ready},
            vecs[i].port ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_mem_ctrl", i), {60'd0, mem_en, mem_we, req0_ready, req1_ready},
            {60'd0, 1'b1, vecs[i].we, 2'b00});
      check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
      check($sformatf("v%0d_mem_be", i), 64'(mem_be), 64'(vecs[i].exp_be));
      check($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].wdata));
      check($sformatf("v%0d_no_early_rsp", i), {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      @(posedge clk); #1;
      mem_rdata = vecs[i].rdata_in;
      @(negedge clk);
      check($sformatf("v%0d_rsp_valid", i), {61'd0, mem_en, rsp1_valid, rsp0_valid},
            vecs[i].port ? 64'd2 : 64'd1);
      check($sformatf("v%0d_rsp_rdata", i), {rsp1_rdata, rsp0_rdata},
            vecs[i].port ? {vecs[i].exp_rdata, 32'h0} : {32'h0, vecs[i].exp_rdata});
      @(posedge clk); #1;
      mem_rdata = '0;
      @(negedge clk);
      check($sformatf("v%0d_rsp_pulse", i), {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    end

    // Both ports request continuously.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
    drive_req(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
    run_grants(10, 1'b0, "both");

    // Port 1 requests alone and is granted back-to-back.
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'hC0, 4'h3, 32'h0000_ABCD);
    run_grants(3, 1'b1, "lone1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
